// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, fault codes, FSM states
// and the request classification helpers used by the LSU and the decoder.
package rv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    FAULT_NONE     = 3'd0,
    FAULT_MISALIGN = 3'd1,
    FAULT_BUS      = 3'd2,
    FAULT_TIMEOUT  = 3'd3,
    FAULT_ILLEGAL  = 3'd4
  } fault_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ISSUE2,
    S_WAIT2,
    S_RESP
  } state_e;

  // Byte-enable pattern of an aligned access of this size, before shifting into its lane.
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return funct3[2] || (funct3[1:0] == 2'b11);
    return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Core-request, response and data-memory bus signals of the LSU. The master modport is the LSU
// itself; the slave modport is its environment (execute stage plus data memory).
interface rv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [2:0]        rsp_fault;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;
  logic              mem_rsp_err;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte enables and store data for the low/high word of an access,
// and extraction plus sign/zero extension of load data from a (possibly two-word) read.
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [63:0] rdata_wide;
  logic [31:0] word;

  // Aligned stores replicate the operand across lanes; a split access needs the true byte shift.
  always_comb begin
    be_wide    = {4'b0000, size_mask(funct3)} << offset;
    be_lo      = be_wide[3:0];
    be_hi      = be_wide[7:4];
    wdata_wide = {32'd0, store_data} << {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   wdata_lo = {4{store_data[7:0]}};
      2'b01:   wdata_lo = {2{store_data[15:0]}};
      default: wdata_lo = store_data;
    endcase
    if (is_misaligned(funct3, offset)) wdata_lo = wdata_wide[31:0];
    wdata_hi   = wdata_wide[63:32];
    rdata_wide = {rdata_hi, rdata_lo} >> {offset, 3'b000};
    word       = rdata_wide[31:0];
    case (funct3)
      F3_LB:   load_data = {{24{word[7]}}, word[7:0]};
      F3_LH:   load_data = {{16{word[15]}}, word[15:0]};
      F3_LBU:  load_data = {24'd0, word[7:0]};
      F3_LHU:  load_data = {16'd0, word[15:0]};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Multi-cycle RV32I load/store unit acting as a valid/ready master to data memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/W accesses into two word transactions.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      reset,
  rv_lsu_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW:0] TO_LIM = (TW+1)'(TIMEOUT_CYCLES);

  state_e            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [TW-1:0]     timer;
  logic [TW:0]       timer_inc;
  logic              timeout_hit;
  logic              accept;
  logic              illegal;
  logic              misaligned;
  logic [2:0]        cur_funct3;
  logic [1:0]        cur_offset;
  logic [31:0]       cur_wdata;
  logic [31:0]       rdata_lo;
  logic [3:0]        be_lo, be_hi;
  logic [31:0]       wdata_lo, wdata_hi, load_data;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [31:0]       rd_lo_q;
`endif

  // In IDLE the lane logic looks at the incoming request so the bus request can issue next cycle.
  always_comb begin
    accept      = (state == S_IDLE) && bus.req_valid && bus.req_ready;
    cur_funct3  = (state == S_IDLE) ? bus.req_funct3 : funct3_q;
    cur_offset  = (state == S_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];
    cur_wdata   = (state == S_IDLE) ? bus.req_wdata : wdata_q;
    illegal     = is_illegal(bus.req_we, bus.req_funct3);
    misaligned  = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    timer_inc   = {1'b0, timer} + (TW+1)'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_inc >= TO_LIM);
`ifdef LSU_MISALIGN_SPLIT_EN
    rdata_lo    = (state == S_WAIT2) ? rd_lo_q : bus.mem_rsp_rdata;
`else
    rdata_lo    = bus.mem_rsp_rdata;
`endif
  end

  rv_lsu_align u_align (
    .funct3     (cur_funct3),
    .offset     (cur_offset),
    .store_data (cur_wdata),
    .rdata_lo   (rdata_lo),
    .rdata_hi   (bus.mem_rsp_rdata),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .wdata_lo   (wdata_lo),
    .wdata_hi   (wdata_hi),
    .load_data  (load_data)
  );

`ifndef LSU_MISALIGN_SPLIT_EN
  logic unused_split;
  assign unused_split = ^{be_hi, wdata_hi, addr_q[ADDR_W-1:2]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      we_q              <= 1'b0;
      funct3_q          <= 3'd0;
      addr_q            <= '0;
      wdata_q           <= 32'd0;
      timer             <= '0;
      bus.req_ready     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_rdata     <= 32'd0;
      bus.rsp_fault     <= FAULT_NONE;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_be        <= 4'd0;
      bus.mem_wdata     <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q           <= 1'b0;
      rd_lo_q           <= 32'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q          <= bus.req_we;
            funct3_q      <= bus.req_funct3;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q       <= misaligned;
`endif
            if (illegal) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= FAULT_ILLEGAL;
            end
`ifndef LSU_MISALIGN_SPLIT_EN
            else if (misaligned) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= FAULT_MISALIGN;
            end
`endif
            else begin
              state             <= S_ISSUE;
              timer             <= '0;
              bus.mem_req_valid <= 1'b1;
              bus.mem_we        <= bus.req_we;
              bus.mem_addr      <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_be        <= be_lo;
              bus.mem_wdata     <= bus.req_we ? wdata_lo : 32'd0;
            end
          end
        end
        S_ISSUE, S_ISSUE2: begin
          timer <= timer_inc[TW-1:0];
          if (bus.mem_req_ready || timeout_hit) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_be        <= 4'd0;
            bus.mem_wdata     <= 32'd0;
          end
          // A handshake in the final allowed cycle still counts; the bus has taken the request.
          if (bus.mem_req_ready) begin
            state <= (state == S_ISSUE) ? S_WAIT : S_WAIT2;
          end else if (timeout_hit) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= FAULT_TIMEOUT;
          end
        end
        S_WAIT, S_WAIT2: begin
          timer <= timer_inc[TW-1:0];
          if (bus.mem_rsp_valid) begin
            if (bus.mem_rsp_err) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= FAULT_BUS;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if ((state == S_WAIT) && split_q) begin
              state             <= S_ISSUE2;
              timer             <= '0;
              rd_lo_q           <= bus.mem_rsp_rdata;
              bus.mem_req_valid <= 1'b1;
              bus.mem_we        <= we_q;
              bus.mem_addr      <= {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
              bus.mem_be        <= be_hi;
              bus.mem_wdata     <= we_q ? wdata_hi : 32'd0;
            end
`endif
            else begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= FAULT_NONE;
              bus.rsp_rdata <= we_q ? 32'd0 : load_data;
            end
          end else if (timeout_hit) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= FAULT_TIMEOUT;
          end
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= 32'd0;
          bus.rsp_fault <= FAULT_NONE;
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed self-checking bench for rv_lsu: store lanes, load extension, faults, timeout
// and asynchronous reset, with the memory side driven step by step.
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  rv_lsu_if #(.ADDR_W(32)) bus ();

  rv_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, observed no end, expected end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = d;
    cycle();
    bus.req_valid  = 1'b0;
  endtask

  // Serves one bus transaction with mem_req_ready held high; ends in the cycle after the response.
  task automatic mem_txn(input string tag, input logic [31:0] rd, input logic err,
                         output logic [31:0] a, output logic [3:0] be, output logic [31:0] wd);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check_output({tag, " req_seen"}, 32'(bus.mem_req_valid), 32'd1);
    a  = bus.mem_addr;
    be = bus.mem_be;
    wd = bus.mem_wdata;
    cycle();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rd;
    bus.mem_rsp_err   = err;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'd0;
    bus.mem_rsp_err   = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] rdata, input logic [2:0] fault);
    check_output({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_output({tag, " rsp_rdata"}, bus.rsp_rdata, rdata);
    check_output({tag, " rsp_fault"}, 32'(bus.rsp_fault), 32'(fault));
    cycle();
    check_output({tag, " pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    check_output({tag, " ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          hi;

    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_funct3    = 3'd0;
    bus.req_addr      = 32'd0;
    bus.req_wdata     = 32'd0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'd0;
    bus.mem_rsp_err   = 1'b0;
    cycle();
    cycle();
    check_output("reset req_ready", 32'(bus.req_ready), 32'd1);
    check_output("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_output("reset mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    cycle();

    // SW at minimum latency: request T+1, response T+2, rsp_valid T+3
    apply_stimulus(1'b1, F3_SW, 32'h10, 32'hDEADBEEF);
    check_output("sw mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
    check_output("sw mem_we", 32'(bus.mem_we), 32'd1);
    check_output("sw mem_addr", bus.mem_addr, 32'h10);
    check_output("sw mem_be", 32'(bus.mem_be), 32'hF);
    check_output("sw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check_output("sw req_ready busy", 32'(bus.req_ready), 32'd0);
    cycle();
    check_output("sw wait mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_output("sw wait rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    check_rsp("sw", 32'd0, 3'd0);

    apply_stimulus(1'b0, F3_LB, 32'h13, 32'd0);
    mem_txn("lb", 32'h80FF0000, 1'b0, a, be, wd);
    check_output("lb mem_addr", a, 32'h10);
    check_output("lb mem_be", 32'(be), 32'h8);
    check_rsp("lb", 32'hFFFFFF80, 3'd0);

    apply_stimulus(1'b0, F3_LBU, 32'h13, 32'd0);
    mem_txn("lbu", 32'h80FF0000, 1'b0, a, be, wd);
    check_rsp("lbu", 32'h00000080, 3'd0);

    apply_stimulus(1'b1, F3_SH, 32'h22, 32'h1234ABCD);
    mem_txn("sh", 32'd0, 1'b0, a, be, wd);
    check_output("sh mem_addr", a, 32'h20);
    check_output("sh mem_be", 32'(be), 32'hC);
    check_output("sh mem_wdata", wd, 32'hABCDABCD);
    check_rsp("sh", 32'd0, 3'd0);

    apply_stimulus(1'b1, F3_SB, 32'h31, 32'h000000A5);
    mem_txn("sb", 32'd0, 1'b0, a, be, wd);
    check_output("sb mem_addr", a, 32'h30);
    check_output("sb mem_be", 32'(be), 32'h2);
    check_output("sb mem_wdata", wd, 32'hA5A5A5A5);
    check_rsp("sb", 32'd0, 3'd0);

    apply_stimulus(1'b0, F3_LH, 32'h02, 32'd0);
    mem_txn("lh", 32'h80017FFF, 1'b0, a, be, wd);
    check_output("lh mem_be", 32'(be), 32'hC);
    check_rsp("lh", 32'hFFFF8001, 3'd0);

    apply_stimulus(1'b0, F3_LHU, 32'h00, 32'd0);
    mem_txn("lhu", 32'hFFFF8765, 1'b0, a, be, wd);
    check_rsp("lhu", 32'h00008765, 3'd0);

    apply_stimulus(1'b0, F3_LW, 32'h04, 32'd0);
    mem_txn("lw", 32'h11223344, 1'b0, a, be, wd);
    check_output("lw mem_we", 32'(bus.mem_we), 32'd0);
    check_rsp("lw", 32'h11223344, 3'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    apply_stimulus(1'b0, F3_LW, 32'h06, 32'd0);
    mem_txn("split lo", 32'h11223344, 1'b0, a, be, wd);
    check_output("split lo addr", a, 32'h04);
    check_output("split lo be", 32'(be), 32'hC);
    mem_txn("split hi", 32'h55667788, 1'b0, a, be, wd);
    check_output("split hi addr", a, 32'h08);
    check_output("split hi be", 32'(be), 32'h3);
    check_rsp("split lw", 32'h77881122, 3'd0);
`else
    apply_stimulus(1'b0, F3_LW, 32'h06, 32'd0);
    check_output("misalign lw mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_rsp("misalign lw", 32'd0, 3'd1);
    apply_stimulus(1'b1, F3_SH, 32'h21, 32'h0000BEEF);
    check_output("misalign sh mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_rsp("misalign sh", 32'd0, 3'd1);
`endif

    apply_stimulus(1'b0, 3'b011, 32'h00, 32'd0);
    check_output("illegal load mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_rsp("illegal load", 32'd0, 3'd4);
    apply_stimulus(1'b1, 3'b100, 32'h00, 32'h12345678);
    check_output("illegal store mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_rsp("illegal store", 32'd0, 3'd4);

    apply_stimulus(1'b0, F3_LW, 32'h40, 32'd0);
    mem_txn("buserr", 32'h12345678, 1'b1, a, be, wd);
    check_rsp("buserr", 32'd0, 3'd2);

    // Memory never accepts: request must be withdrawn after exactly 8 cycles
    bus.mem_req_ready = 1'b0;
    apply_stimulus(1'b0, F3_LW, 32'h50, 32'd0);
    hi = 0;
    while (bus.mem_req_valid === 1'b1 && hi < 30) begin
      hi++;
      cycle();
    end
    check_output("timeout request cycles", 32'(hi), 32'd8);
    bus.mem_req_ready = 1'b1;
    check_rsp("timeout", 32'd0, 3'd3);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hAAAA5555;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    check_output("late rsp ignored", 32'(bus.rsp_valid), 32'd0);
    check_output("late rsp ready", 32'(bus.req_ready), 32'd1);

    // Asynchronous reset while waiting for the memory response
    apply_stimulus(1'b0, F3_LW, 32'h60, 32'd0);
    cycle();
    check_output("rst in wait req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_output("rst async req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rst async mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check_output("rst async rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst async rsp_fault", 32'(bus.rsp_fault), 32'd0);
    cycle();
    reset = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'hFFFFFFFF;
    cycle();
    bus.mem_rsp_valid = 1'b0;
    check_output("stray rsp no pulse", 32'(bus.rsp_valid), 32'd0);
    cycle();
    check_output("stray rsp still quiet", 32'(bus.rsp_valid), 32'd0);
    check_output("stray rsp ready", 32'(bus.req_ready), 32'd1);

    apply_stimulus(1'b0, F3_LW, 32'h70, 32'd0);
    mem_txn("after reset lw", 32'hCAFEF00D, 1'b0, a, be, wd);
    check_output("after reset addr", a, 32'h70);
    check_rsp("after reset lw", 32'hCAFEF00D, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
